radix_4_otfc_v1: RTL and testbench

- On-the-fly quotient converter for the radix-4 SRT integer divider.
- Consumes the one-hot quotient digit stream {-2,-1,0,+1,+2} produced each iteration by the quotient digit selector.
- Maintains the Q/QM register pair, tracks the iteration count, and applies the final negative-remainder correction.
- Returns the binary quotient to the divider top over a valid/ready handshake.

---
 rtl/radix_4_otfc_v1.sv | 143 ++++++++++++++
 tb/tb_radix_4_otfc_v1.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/radix_4_otfc_v1.sv
// radix_4_otfc_v1: on-the-fly quotient converter for a radix-4 SRT divider.
// Folds the one-hot digit stream {-2,-1,0,+1,+2} into the Q/QM register
// pair, applies the negative-remainder correction and hands the quotient
// out over a valid/ready handshake.
// Optional build macro RADIX_4_OTFC_SIGNED_EN adds quot_neg_i, which
// negates the corrected quotient (two's complement) when set at start.
module radix_4_otfc_v1 #(
    parameter int WIDTH             = 32,
    parameter int QUOT_ONEHOT_WIDTH = 5,
    parameter int ITER_W            = $clog2(WIDTH/2+1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush_i,
    input  logic                         start_valid_i,
    output logic                         start_ready_o,
    input  logic [ITER_W-1:0]            iter_num_i,
`ifdef RADIX_4_OTFC_SIGNED_EN
    input  logic                         quot_neg_i,
`endif
    input  logic                         quot_digit_valid_i,
    output logic                         quot_digit_ready_o,
    input  logic [QUOT_ONEHOT_WIDTH-1:0] quot_digit_i,
    input  logic                         rem_sign_valid_i,
    input  logic                         rem_is_neg_i,
    output logic                         finish_valid_o,
    input  logic                         finish_ready_i,
    output logic [WIDTH-1:0]             quot_o
);

    localparam logic [ITER_W-1:0] HALF_CNT = ITER_W'(WIDTH/2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        CORR = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_qm;
    logic [ITER_W-1:0]  r_cnt;
    logic [WIDTH-1:0]   r_quot;
    logic [ITER_W-1:0]  w_cnt_init;
    logic [WIDTH-1:0]   w_q_sh;
    logic [WIDTH-1:0]   w_qm_sh;
    logic [WIDTH-1:0]   w_q_next;
    logic [WIDTH-1:0]   w_qm_next;
    logic [WIDTH-1:0]   w_sel;
    logic               w_digit_take;
`ifdef RADIX_4_OTFC_SIGNED_EN
    logic               r_quot_neg;
`endif

    assign w_cnt_init    = (iter_num_i > HALF_CNT) ? HALF_CNT : iter_num_i;
    assign w_q_sh        = {r_q[WIDTH-3:0], 2'b00};
    assign w_qm_sh       = {r_qm[WIDTH-3:0], 2'b00};
    assign w_digit_take  = (r_state == ITER) && quot_digit_valid_i;
    assign w_sel         = rem_is_neg_i ? r_qm : r_q;

    assign start_ready_o      = (r_state == IDLE);
    assign quot_digit_ready_o = (r_state == ITER);
    assign finish_valid_o     = (r_state == DONE);
    assign quot_o             = r_quot;

    // Digit decode: lowest set bit wins, an all-zero vector acts as digit 0
    always_comb begin
        w_q_next  = w_q_sh;
        w_qm_next = w_qm_sh | WIDTH'(3);
        if (quot_digit_i[0]) begin
            w_q_next  = w_qm_sh | WIDTH'(2);
            w_qm_next = w_qm_sh | WIDTH'(1);
        end else if (quot_digit_i[1]) begin
            w_q_next  = w_qm_sh | WIDTH'(3);
            w_qm_next = w_qm_sh | WIDTH'(2);
        end else if (quot_digit_i[2]) begin
            w_q_next  = w_q_sh;
            w_qm_next = w_qm_sh | WIDTH'(3);
        end else if (quot_digit_i[3]) begin
            w_q_next  = w_q_sh | WIDTH'(1);
            w_qm_next = w_q_sh;
        end else if (quot_digit_i[4]) begin
            w_q_next  = w_q_sh | WIDTH'(2);
            w_qm_next = w_q_sh | WIDTH'(1);
        end
    end

    // Next-state logic; flush overrides every other event
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (start_valid_i) w_state_next = (w_cnt_init == '0) ? CORR : ITER;
            ITER: if (quot_digit_valid_i && (r_cnt == ITER_W'(1))) w_state_next = CORR;
            CORR: if (rem_sign_valid_i) w_state_next = DONE;
            DONE: if (finish_ready_i) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
        if (flush_i) w_state_next = IDLE;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    // Q/QM accumulation, digit counter and corrected quotient capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q    <= '0;
            r_qm   <= '1;
            r_cnt  <= '0;
            r_quot <= '0;
`ifdef RADIX_4_OTFC_SIGNED_EN
            r_quot_neg <= 1'b0;
`endif
        end else if (!flush_i) begin
            if ((r_state == IDLE) && start_valid_i) begin
                r_q   <= '0;
                r_qm  <= '1;
                r_cnt <= w_cnt_init;
`ifdef RADIX_4_OTFC_SIGNED_EN
                r_quot_neg <= quot_neg_i;
`endif
            end
            if (w_digit_take) begin
                r_q   <= w_q_next;
                r_qm  <= w_qm_next;
                r_cnt <= r_cnt - ITER_W'(1);
            end
            if ((r_state == CORR) && rem_sign_valid_i) begin
`ifdef RADIX_4_OTFC_SIGNED_EN
                r_quot <= r_quot_neg ? (~w_sel + WIDTH'(1)) : w_sel;
`else
                r_quot <= w_sel;
`endif
            end
        end
    end

endmodule

// File: tb/tb_radix_4_otfc_v1.sv
// Directed self-checking bench for radix_4_otfc_v1 (WIDTH = 32).
module tb_radix_4_otfc_v1;

    localparam int WIDTH  = 32;
    localparam int ITER_W = $clog2(WIDTH/2+1);

    localparam logic [4:0] D_M2 = 5'b00001;
    localparam logic [4:0] D_M1 = 5'b00010;
    localparam logic [4:0] D_Z  = 5'b00100;
    localparam logic [4:0] D_P1 = 5'b01000;
    localparam logic [4:0] D_P2 = 5'b10000;

    logic              clk;
    logic              rst_n;
    logic              flush_i;
    logic              start_valid_i;
    logic              start_ready_o;
    logic [ITER_W-1:0] iter_num_i;
    logic              quot_neg_i;
    logic              quot_digit_valid_i;
    logic              quot_digit_ready_o;
    logic [4:0]        quot_digit_i;
    logic              rem_sign_valid_i;
    logic              rem_is_neg_i;
    logic              finish_valid_o;
    logic              finish_ready_i;
    logic [WIDTH-1:0]  quot_o;

    int total = 0;
    int bad   = 0;

    radix_4_otfc_v1 #(.WIDTH(WIDTH)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .flush_i            (flush_i),
        .start_valid_i      (start_valid_i),
        .start_ready_o      (start_ready_o),
        .iter_num_i         (iter_num_i),
`ifdef RADIX_4_OTFC_SIGNED_EN
        .quot_neg_i         (quot_neg_i),
`endif
        .quot_digit_valid_i (quot_digit_valid_i),
        .quot_digit_ready_o (quot_digit_ready_o),
        .quot_digit_i       (quot_digit_i),
        .rem_sign_valid_i   (rem_sign_valid_i),
        .rem_is_neg_i       (rem_is_neg_i),
        .finish_valid_o     (finish_valid_o),
        .finish_ready_i     (finish_ready_i),
        .quot_o             (quot_o)
    );

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it, reports tag/observed/expected on mismatch
    task automatic checkOutput(input string tag, input logic [WIDTH-1:0] obs,
                               input logic [WIDTH-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue a start request for n digits; must be accepted in IDLE
    task automatic applyStimulus(input logic [ITER_W-1:0] n, input logic neg);
        checkOutput("start_ready_before_start", {31'd0, start_ready_o}, 32'd1);
        start_valid_i = 1'b1;
        iter_num_i    = n;
        quot_neg_i    = neg;
        @(negedge clk);
        start_valid_i = 1'b0;
        quot_neg_i    = 1'b0;
    endtask

    // Present one digit for one cycle while the converter is in ITER
    task automatic sendDigit(input logic [4:0] d);
        checkOutput("digit_ready_in_iter", {31'd0, quot_digit_ready_o}, 32'd1);
        quot_digit_valid_i = 1'b1;
        quot_digit_i       = d;
        @(negedge clk);
        quot_digit_valid_i = 1'b0;
        quot_digit_i       = 5'b00000;
    endtask

    // Deliver remainder sign in CORR and check the result a cycle later
    task automatic corrStep(input logic neg, input logic [WIDTH-1:0] exp, input string tag);
        checkOutput("corr_finish_valid_low", {31'd0, finish_valid_o}, 32'd0);
        checkOutput("corr_digit_ready_low", {31'd0, quot_digit_ready_o}, 32'd0);
        rem_sign_valid_i = 1'b1;
        rem_is_neg_i     = neg;
        @(negedge clk);
        rem_sign_valid_i = 1'b0;
        rem_is_neg_i     = 1'b0;
        checkOutput("done_finish_valid", {31'd0, finish_valid_o}, 32'd1);
        checkOutput(tag, quot_o, exp);
    endtask

    // Consumer takes the quotient; converter is back in IDLE afterwards
    task automatic acceptStep();
        finish_ready_i = 1'b1;
        @(negedge clk);
        finish_ready_i = 1'b0;
        checkOutput("after_accept_valid_low", {31'd0, finish_valid_o}, 32'd0);
        checkOutput("after_accept_idle", {31'd0, start_ready_o}, 32'd1);
    endtask

    // Directed test sequence
    initial begin
        rst_n = 1'b0; flush_i = 1'b0; start_valid_i = 1'b0; iter_num_i = '0;
        quot_neg_i = 1'b0; quot_digit_valid_i = 1'b0; quot_digit_i = 5'b0;
        rem_sign_valid_i = 1'b0; rem_is_neg_i = 1'b0; finish_ready_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_start_ready", {31'd0, start_ready_o}, 32'd1);
        checkOutput("reset_digit_ready", {31'd0, quot_digit_ready_o}, 32'd0);
        checkOutput("reset_finish_valid", {31'd0, finish_valid_o}, 32'd0);
        checkOutput("reset_quot", quot_o, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // +1,+2 positive remainder -> 6
        applyStimulus(2, 1'b0);
        sendDigit(D_P1); sendDigit(D_P2);
        corrStep(1'b0, 32'd6, "pos_rem_quot");
        acceptStep();

        // +1,+2 negative remainder -> QM = 5
        applyStimulus(2, 1'b0);
        sendDigit(D_P1); sendDigit(D_P2);
        corrStep(1'b1, 32'd5, "neg_rem_quot");
        acceptStep();

        // -1,+2 -> -2
        applyStimulus(2, 1'b0);
        sendDigit(D_M1); sendDigit(D_P2);
        corrStep(1'b0, 32'hFFFF_FFFE, "neg_digit_m1p2");
        acceptStep();

        // -2,-2 -> -10
        applyStimulus(2, 1'b0);
        sendDigit(D_M2); sendDigit(D_M2);
        corrStep(1'b0, 32'hFFFF_FFF6, "neg_digit_m2m2");
        acceptStep();

        // Zero iterations go straight to CORR
        applyStimulus(0, 1'b0);
        corrStep(1'b0, 32'd0, "zero_iter_pos");
        acceptStep();
        applyStimulus(0, 1'b0);
        corrStep(1'b1, 32'hFFFF_FFFF, "zero_iter_neg");
        acceptStep();

        // Clamp 31 -> 16 digits of +1 with a valid gap and a noise digit
        applyStimulus(31, 1'b0);
        for (int i = 0; i < 16; i++) begin
            if (i == 5) begin
                quot_digit_i = D_M2;
                repeat (3) @(negedge clk);
                quot_digit_i = 5'b0;
                checkOutput("gap_still_iter", {31'd0, quot_digit_ready_o}, 32'd1);
            end
            sendDigit(D_P1);
        end
        corrStep(1'b0, 32'h5555_5555, "clamp16_quot");
        // Backpressure: quotient must stay stable while not accepted
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp_valid_held", {31'd0, finish_valid_o}, 32'd1);
            checkOutput("bp_quot_stable", quot_o, 32'h5555_5555);
        end
        acceptStep();

        // Flush in ITER after 3 digits, with a digit offered the same cycle
        applyStimulus(4, 1'b0);
        sendDigit(D_M1); sendDigit(D_M1); sendDigit(D_M1);
        flush_i = 1'b1; quot_digit_valid_i = 1'b1; quot_digit_i = D_P2;
        @(negedge clk);
        flush_i = 1'b0; quot_digit_valid_i = 1'b0; quot_digit_i = 5'b0;
        checkOutput("flush_idle", {31'd0, start_ready_o}, 32'd1);
        checkOutput("flush_digit_ready", {31'd0, quot_digit_ready_o}, 32'd0);
        checkOutput("flush_finish_valid", {31'd0, finish_valid_o}, 32'd0);
        applyStimulus(2, 1'b0);
        sendDigit(D_P2); sendDigit(D_Z);
        corrStep(1'b0, 32'd8, "post_flush_quot");
        acceptStep();

        // Stray digit/remainder strobes in IDLE have no effect
        quot_digit_valid_i = 1'b1; quot_digit_i = D_P1;
        rem_sign_valid_i = 1'b1; rem_is_neg_i = 1'b1;
        @(negedge clk);
        quot_digit_valid_i = 1'b0; rem_sign_valid_i = 1'b0; rem_is_neg_i = 1'b0;
        checkOutput("stray_stay_idle", {31'd0, start_ready_o}, 32'd1);
        checkOutput("stray_quot_held", quot_o, 32'd8);

        // Multi-hot 11000 -> +1, all-zero -> 0: Q = 4
        applyStimulus(2, 1'b0);
        sendDigit(5'b11000); sendDigit(5'b00000);
        corrStep(1'b0, 32'd4, "illegal_digits_quot");
        acceptStep();

        // Asynchronous reset in DONE
        applyStimulus(2, 1'b0);
        sendDigit(D_P1); sendDigit(D_P2);
        corrStep(1'b0, 32'd6, "pre_reset_quot");
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_valid", {31'd0, finish_valid_o}, 32'd0);
        checkOutput("async_rst_quot", quot_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_idle", {31'd0, start_ready_o}, 32'd1);

`ifdef RADIX_4_OTFC_SIGNED_EN
        // Signed: negate 6 -> 0xFFFFFFFA
        applyStimulus(2, 1'b1);
        sendDigit(D_P1); sendDigit(D_P2);
        corrStep(1'b0, 32'hFFFF_FFFA, "signed_neg_quot");
        acceptStep();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
